// File: rtl/main_memory.sv
// Multi-cycle byte-addressed backing memory answering the cache's word-level
// miss traffic: one 32-bit big-endian read or write at a time, fixed latency.
module main_memory #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        ready,
    output logic        stall
);

    localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        out_q, out_d;

    logic [7:0]         mem_q [MEM_BYTES];

    logic               acc_en;
    logic               acc_wr;
    logic [ADDR_W-1:0]  acc_addr;
    logic [31:0]        acc_data;
    logic [ADDR_W-1:0]  ba0, ba1, ba2, ba3;
    logic [31:0]        rd_word;
    logic               mem_we;

    // Only the low address bits select a byte; the rest alias.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    // Next-state logic; acc_* describes the access committed on this edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        acc_en   = 1'b0;
        acc_wr   = wr_q;
        acc_addr = addr_q;
        acc_data = data_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (req) begin
                    wr_d   = write;
                    addr_d = addr[ADDR_W-1:0];
                    data_d = in;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        // Single-cycle latency: access happens on the accepting edge.
                        state_d  = RESP;
                        acc_en   = 1'b1;
                        acc_wr   = write;
                        acc_addr = addr[ADDR_W-1:0];
                        acc_data = in;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    acc_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Big-endian word assembly; byte addresses wrap at the top of memory.
    always_comb begin
        ba0     = acc_addr;
        ba1     = acc_addr + ADDR_W'(1);
        ba2     = acc_addr + ADDR_W'(2);
        ba3     = acc_addr + ADDR_W'(3);
        rd_word = {mem_q[ba0], mem_q[ba1], mem_q[ba2], mem_q[ba3]};
        mem_we  = acc_en & acc_wr;
        out_d   = out_q;
        if (acc_en && !acc_wr) begin
            out_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ba0] <= acc_data[31:24];
            mem_q[ba1] <= acc_data[23:16];
            mem_q[ba2] <= acc_data[15:8];
            mem_q[ba3] <= acc_data[7:0];
        end
    end

    assign out   = out_q;
    assign ready = (state_q == RESP);
    assign stall = ~rst & ((state_q == WAIT) | (((state_q == IDLE) | (state_q == RESP)) & req));

endmodule
